// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader
//  Purpose  : Boot-time instruction loader. Takes a byte stream over a
//             valid/ready handshake, reads a 16-bit big-endian word count N,
//             assembles N big-endian instruction words and writes them into
//             instruction memory starting at address 0, then releases the CPU.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   system clock, rising edge
//    RST        in   synchronous reset, active-high
//    start      in   begin a load session (1-cycle pulse)
//    in_data    in   stream byte
//    in_valid   in   in_data valid
//    in_ready   out  loader accepts a byte this cycle
//    mem_we     out  instruction memory write strobe (one cycle per word)
//    mem_addr   out  write address
//    mem_wdata  out  write data
//    cpu_hold   out  1 = keep CPU stalled
//    done       out  load completed successfully
//    err        out  header word count exceeds memory depth
// ============================================================================
module instr_loader #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam int c_BYTES  = WORD_WIDTH / 8;
    localparam int c_BCNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_BCNT_W-1:0] c_LAST_BYTE = c_BCNT_W'(c_BYTES - 1);
    localparam longint unsigned c_DEPTH = 64'd1 << ADDR_WIDTH;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LEN   = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [2:0] c_ST_ERR   = 3'd5;

    logic [2:0]            r_state;
    logic [c_BCNT_W-1:0]   r_bcnt;     // byte position within header / word
    logic [15:0]           r_len;      // word count N from the header
    logic [ADDR_WIDTH-1:0] r_index;    // index of the word being assembled
    logic [WORD_WIDTH-1:0] r_word;     // assembly register, MSB-first shift
    logic                  r_in_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0] r_mem_wdata;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_err;

    logic                  w_fire;
    logic [15:0]           w_len_full;
    logic [WORD_WIDTH-1:0] w_word_next;
    logic                  w_last_word;

    assign w_fire      = in_valid && r_in_ready;
    assign w_len_full  = {r_len[15:8], in_data};
    // Truncating cast keeps the low WORD_WIDTH bits, so the oldest byte
    // falls off the top; this also works when a word is a single byte.
    assign w_word_next = WORD_WIDTH'({r_word, in_data});
    assign w_last_word = ((32'(r_index) + 32'd1) == 32'(r_len));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_ST_IDLE;
            r_bcnt      <= '0;
            r_len       <= '0;
            r_index     <= '0;
            r_word      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                    if (start) begin
                        r_state    <= c_ST_LEN;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_index    <= '0;
                        r_bcnt     <= '0;
                    end
                end
                c_ST_LEN: begin
                    if (w_fire) begin
                        if (r_bcnt == '0) begin
                            r_len[15:8] <= in_data;
                            r_bcnt      <= c_BCNT_W'(1);
                        end else begin
                            r_len  <= w_len_full;
                            r_bcnt <= '0;
                            if (w_len_full == 16'd0) begin
                                r_state    <= c_ST_DONE;
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                                r_cpu_hold <= 1'b0;
                            end else if (64'(w_len_full) > c_DEPTH) begin
                                r_state    <= c_ST_ERR;
                                r_in_ready <= 1'b0;
                                r_err      <= 1'b1;
                            end else begin
                                r_state <= c_ST_DATA;
                            end
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_fire) begin
                        r_word <= w_word_next;
                        if (r_bcnt == c_LAST_BYTE) begin
                            // Word complete: strobe the write and pause the
                            // stream for the single WRITE cycle.
                            r_bcnt      <= '0;
                            r_state     <= c_ST_WRITE;
                            r_in_ready  <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_index;
                            r_mem_wdata <= w_word_next;
                        end else begin
                            r_bcnt <= r_bcnt + c_BCNT_W'(1);
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (w_last_word) begin
                        r_state    <= c_ST_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_index    <= r_index + ADDR_WIDTH'(1);
                        r_state    <= c_ST_DATA;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_loader
//  Purpose  : Self-checking bench for instr_loader. Byte streams are built
//             from word lists; the expected memory writes (address, data, in
//             order) are derived from the stream format and compared against
//             every observed write strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int BYTES      = WORD_WIDTH / 8;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  start = 1'b0;
    logic [7:0]            in_data = 8'h00;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;

    instr_loader #(.WORD_WIDTH(WORD_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Expected writes in order, and writes actually observed.
    logic [ADDR_WIDTH-1:0] exp_addr_q[$];
    logic [WORD_WIDTH-1:0] exp_data_q[$];
    logic [ADDR_WIDTH-1:0] seen_addr_q[$];
    logic [WORD_WIDTH-1:0] seen_data_q[$];
    bit   cmp_en  = 1'b0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every write strobe is matched against the model.
    always @(negedge CLK) begin
        if (cmp_en && RST !== 1'b1) begin
            check("hold_is_not_done", cpu_hold, done ? 32'd0 : 32'd1);
            if (mem_we === 1'b1) begin
                seen_addr_q.push_back(mem_addr);
                seen_data_q.push_back(mem_wdata);
                check("we_single_cycle", prev_we, 32'd0);
                check("in_ready_low_on_write", in_ready, 32'd0);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                             mem_addr, mem_wdata);
                end else begin
                    check("write_addr", mem_addr, exp_addr_q.pop_front());
                    check("write_data", mem_wdata, exp_data_q.pop_front());
                end
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("start_in_ready", in_ready, 32'd1);
        check("start_cpu_hold", cpu_hold, 32'd1);
        check("start_done_clr", done, 32'd0);
        check("start_err_clr", err, 32'd0);
    endtask

    // Present bytes with random valid gaps and optional start noise. After the
    // last byte of each data word, the very next cycle must carry the strobe.
    task automatic drive_bytes(input logic [7:0] bq[$], input int gap_pct,
                               input int noise_pct, input bit has_words);
        bit pend = 1'b0;
        bit accepted;
        int budget;
        for (int k = 0; k < bq.size(); k++) begin
            accepted = 1'b0;
            budget   = 0;
            while (!accepted) begin
                in_data  = bq[k];
                in_valid = ($urandom_range(99) >= gap_pct);
                start    = ($urandom_range(99) < noise_pct);
                @(negedge CLK);
                if (pend) begin
                    check("we_after_last_byte", mem_we, 32'd1);
                    pend = 1'b0;
                end
                accepted = in_valid && in_ready;
                budget++;
                @(posedge CLK); #1;
                if (!accepted && budget > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL byte_accept_timeout actual=not accepted required=byte %0d accepted", k);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
            if (has_words && k >= 2 && ((k - 2) % BYTES) == BYTES - 1) pend = 1'b1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (pend) begin
            @(negedge CLK);
            check("we_after_last_byte", mem_we, 32'd1);
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_load(input logic [WORD_WIDTH-1:0] wq[$], input int n,
                           input int gap_pct, input int noise_pct);
        logic [7:0] bq[$];
        logic [15:0] nn;
        logic [WORD_WIDTH-1:0] w;
        bit valid_n;
        nn = 16'(n);
        valid_n = (n >= 1 && n <= DEPTH);
        bq.push_back(nn[15:8]);
        bq.push_back(nn[7:0]);
        if (valid_n) begin
            for (int i = 0; i < n; i++) begin
                w = wq[i];
                exp_addr_q.push_back(ADDR_WIDTH'(i));
                exp_data_q.push_back(w);
                for (int b = BYTES - 1; b >= 0; b--) bq.push_back(w[b*8 +: 8]);
            end
        end
        seen_addr_q.delete();
        seen_data_q.delete();
        pulse_start();
        drive_bytes(bq, gap_pct, noise_pct, valid_n);
        @(negedge CLK);
        if (n > DEPTH) begin
            check("err_flag", err, 32'd1);
            check("err_cpu_hold", cpu_hold, 32'd1);
            check("err_in_ready", in_ready, 32'd0);
            check("err_done", done, 32'd0);
        end else begin
            check("done_flag", done, 32'd1);
            check("done_cpu_hold", cpu_hold, 32'd0);
            check("done_in_ready", in_ready, 32'd0);
            check("done_err", err, 32'd0);
        end
        check("pending_writes", exp_addr_q.size(), 32'd0);
        check("write_count", seen_addr_q.size(), valid_n ? 32'(n) : 32'd0);
        @(posedge CLK); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 32'd0);
        check({tag, "_mem_we"}, mem_we, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_cpu_hold"}, cpu_hold, 32'd1);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_err"}, err, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORD_WIDTH-1:0] wq[$];
        logic [7:0] part[$];
        int n;

        // Reset state
        RST = 1'b1;
        @(posedge CLK); #1;
        check_reset_values("reset");
        RST = 1'b0;
        cmp_en = 1'b1;
        @(posedge CLK); #1;
        check("idle_ignores_valid_ready", in_ready, 32'd0);

        // Directed 2-word load: 00 02 | 12 34 | AB CD
        wq = '{16'h1234, 16'hABCD};
        do_load(wq, 2, 0, 0);
        if (seen_data_q.size() == 2) begin
            check("s1_addr0", seen_addr_q[0], 32'd0);
            check("s1_data0", seen_data_q[0], 32'h1234);
            check("s1_addr1", seen_addr_q[1], 32'd1);
            check("s1_data1", seen_data_q[1], 32'hABCD);
        end

        // Empty program: straight to DONE without writes
        wq.delete();
        do_load(wq, 0, 0, 0);

        // Oversized header, then extra bytes must be refused
        do_load(wq, DEPTH + 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge CLK);
            check("err_refuses_bytes", in_ready, 32'd0);
            check("err_sticky", err, 32'd1);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        wq = '{16'h5A5A};
        do_load(wq, 1, 0, 0);

        // Same 2-word stream with 50% valid gaps and start noise
        wq = '{16'h1234, 16'hABCD};
        do_load(wq, 2, 50, 0);
        do_load(wq, 2, 50, 10);

        // Reset after the first data byte, then a clean reload
        part = '{8'h00, 8'h02, 8'h12};
        pulse_start();
        drive_bytes(part, 0, 0, 1'b0);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_reset_values("midreset");
        RST = 1'b0;
        do_load(wq, 2, 0, 0);

        // Randomized loads
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, 8);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(WORD_WIDTH'($urandom));
            do_load(wq, n, 50, 10);
        end

        // Full-depth load (N == DEPTH is legal)
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back(WORD_WIDTH'($urandom));
        do_load(wq, DEPTH, 0, 0);
        if (seen_addr_q.size() == DEPTH)
            check("full_last_addr", seen_addr_q[DEPTH-1], 32'(DEPTH - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
